// File: rtl/l4_mux4_arb_if.sv
// Requester-side bundle for the 4-way path arbiter: per-requester request
// lines in, one-hot grant, path-mux select and busy flag out.
interface l4_mux4_arb_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  // Requester side: raises req, observes the arbiter decision
  modport master (output req, input gnt, sel, busy);
  // Arbiter side: samples req, drives grant and select
  modport slave  (input req, output gnt, sel, busy);
endinterface

// File: rtl/l4_mux4_arb.sv
// Round-robin arbiter for the shared 4-input datapath. One owner at a time,
// burst-limited only while someone else is waiting, and a single dead TURN
// cycle between owners. gnt/sel/busy all come straight from flops.
module l4_mux4_arb #(
  parameter int MAX_BURST = 16,
  parameter int CNT_BITS  = 5
) (
  input  logic         clk,
  input  logic         reset,
  l4_mux4_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // The counter holds (granted cycles - 1) so that MAX_BURST = 2**CNT_BITS
  // still fits in CNT_BITS bits; BURST_LAST marks the final allowed cycle.
  localparam logic [CNT_BITS-1:0] BURST_LAST = CNT_BITS'(MAX_BURST - 1);

  state_t              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [CNT_BITS-1:0] burst_q, burst_d;
  logic                busy_q, busy_d;

  logic                win_vld;
  logic [1:0]          win;
  logic                release_own;
  logic                at_limit;
  logic                others_wait;

  // Rotated priority search: first set req starting at ptr wins
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    // Walk from the farthest offset down so the nearest one overwrites last
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win     = ptr_q + 2'(k);
      end
    end
  end

  // Owner status terms used while in GRANT (owner is sel_q)
  always_comb begin
    release_own = ~bus.req[sel_q];
    at_limit    = (burst_q == BURST_LAST);
    others_wait = |(bus.req & ~gnt_q);
  end

  // State register plus the registered outputs it carries
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      burst_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; release and preemption collapse into one TURN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_vld) state_d = GRANT;
      GRANT: if (release_own || (at_limit && others_wait)) state_d = TURN;
      TURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; the owner never changes inside GRANT
  always_comb begin
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win + 2'd1;
          burst_d = '0;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
        if (state_d == TURN) begin
          gnt_d = 4'b0000;
        end else if (at_limit) begin
          // Nobody else waiting: renew the burst instead of wrapping
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: gnt_d = 4'b0000;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule
